// File: rtl/if_fetch_queue.sv
// if_fetch_queue
// Instruction-fetch stage with a decoupling instruction queue. It holds the
// program counter and issues sequential fetches to a synchronous memory with
// one-cycle latency. Each returned instruction is buffered with its PC in a
// FIFO, and the FIFO feeds decode over a valid/ready handshake. A redirect
// flushes all buffered and in-flight fetches and restarts fetch at the target.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   redirect            taken branch/jump; redirect_pc is the new fetch PC
//   imem_req            fetch request this cycle (combinational)
//   imem_addr           fetch address (= pc_q)
//   imem_rdata          instruction for the request issued in the previous cycle
//   out_valid           queue head valid
//   out_ready           decode accepts the head
//   out_instr/out_pc    head instruction and its PC
//   out_pc_plus4        out_pc + PC_STEP (wraps)
//   count               occupied queue entries
module if_fetch_queue #(
    parameter int unsigned     PC_W     = 16,
    parameter int unsigned     INSTR_W  = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       imem_req,
    output logic [PC_W-1:0]            imem_addr,
    input  logic [INSTR_W-1:0]         imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [PC_W-1:0]            out_pc,
    output logic [PC_W-1:0]            out_pc_plus4,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    // One extra bit so count + inflight never wraps in the credit check.
    localparam int unsigned OCC_W = CNT_W + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("if_fetch_queue: DEPTH must be a power of two and at least 2");
    end

    // Architectural state
    logic [PC_W-1:0]    pc_q;
    logic               inflight_q;
    logic [PC_W-1:0]    resp_pc_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;

    // Queue storage (data only, no reset needed)
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]    pc_mem    [DEPTH];

    // Next-state values
    logic [PC_W-1:0]    pc_d;
    logic               inflight_d;
    logic [PC_W-1:0]    resp_pc_d;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_d;
    logic [CNT_W-1:0]   count_d;

    logic               pop_c;
    logic               push_c;
    logic               issue_c;
    logic [OCC_W-1:0]   occ_after_c;

    // Handshake, credit check and response capture decisions
    always_comb begin
        pop_c       = 1'b0;
        push_c      = 1'b0;
        issue_c     = 1'b0;
        occ_after_c = '0;

        pop_c = (count_q != '0) && out_ready;
        // Entries that will be held once the outstanding response lands and
        // the current pop retires; a new request is allowed only if it fits.
        occ_after_c = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop_c);
        issue_c     = !reset && !redirect && (occ_after_c < OCC_W'(DEPTH));
        push_c      = inflight_q && !redirect && !reset;
    end

    // Next-state logic for PC, in-flight tracking, pointers and occupancy
    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        resp_pc_d  = resp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (reset) begin
            pc_d       = RESET_PC;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else if (redirect) begin
            // Queue and the pending response are dropped; a coinciding pop
            // has already been taken by decode.
            pc_d       = redirect_pc;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue_c) begin
                pc_d       = pc_q + PC_W'(PC_STEP);
                inflight_d = 1'b1;
                resp_pc_d  = pc_q;
            end else begin
                inflight_d = 1'b0;
            end

            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end

            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        pc_q       <= pc_d;
        inflight_q <= inflight_d;
        resp_pc_q  <= resp_pc_d;
        rd_ptr_q   <= rd_ptr_d;
        wr_ptr_q   <= wr_ptr_d;
        count_q    <= count_d;
    end

    // Queue write: capture the returning instruction with its fetch PC
    always_ff @(posedge clk) begin
        if (push_c) begin
            instr_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]    <= resp_pc_q;
        end
    end

    // Output drive
    always_comb begin
        imem_req     = issue_c;
        imem_addr    = pc_q;
        out_valid    = (count_q != '0);
        out_instr    = instr_mem[rd_ptr_q];
        out_pc       = pc_mem[rd_ptr_q];
        out_pc_plus4 = pc_mem[rd_ptr_q] + PC_W'(PC_STEP);
        count        = count_q;
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: two instances (DEPTH=4 and DEPTH=2) share all
// control inputs and each gets its own one-cycle-latency memory. A queue-level
// model (head PC plus entry count, since buffered PCs are always consecutive)
// predicts every output each cycle; directed literal checks pin the model.
module tb_if_fetch_queue;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        out_ready;

    logic        req0, req1;
    logic [15:0] addr0, addr1;
    logic [31:0] rdata0, rdata1;
    logic        valid0, valid1;
    logic [31:0] instr0, instr1;
    logic [15:0] opc0, opc1, opc40, opc41;
    logic [2:0]  cnt0;
    logic [1:0]  cnt1;

    if_fetch_queue #(.PC_W(16), .INSTR_W(32), .DEPTH(4), .RESET_PC(RST_PC), .PC_STEP(4)) u0 (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(req0), .imem_addr(addr0), .imem_rdata(rdata0),
        .out_valid(valid0), .out_ready(out_ready), .out_instr(instr0),
        .out_pc(opc0), .out_pc_plus4(opc40), .count(cnt0));

    if_fetch_queue #(.PC_W(16), .INSTR_W(32), .DEPTH(2), .RESET_PC(RST_PC), .PC_STEP(4)) u1 (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1),
        .out_valid(valid1), .out_ready(out_ready), .out_instr(instr1),
        .out_pc(opc1), .out_pc_plus4(opc41), .count(cnt1));

    function automatic logic [31:0] word(input logic [15:0] a);
        return {a ^ 16'h5A3C, a};
    endfunction

    // Synchronous memories; garbage when no request so a stale capture shows up
    always @(posedge clk) rdata0 <= req0 ? word(addr0) : 32'hDEAD_BEEF;
    always @(posedge clk) rdata1 <= req1 ? word(addr1) : 32'hDEAD_BEEF;

    // Model state per instance
    int          depth_of [2];
    int          m_n      [2];
    logic [15:0] m_head   [2];
    logic [15:0] m_pc     [2];
    logic [15:0] m_ipc    [2];
    logic        m_inf    [2];
    int          since_flush;

    int checks;
    int errors;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic exp_req(input int i);
        int occ;
        logic pop;
        pop = (m_n[i] != 0) && out_ready;
        occ = m_n[i] + (m_inf[i] ? 1 : 0) - (pop ? 1 : 0);
        return !reset && !redirect && (occ < depth_of[i]);
    endfunction

    // Per-cycle comparison of both instances against the model
    task automatic compare_all();
        logic        a_req   [2];
        logic [15:0] a_addr  [2];
        logic        a_valid [2];
        logic [31:0] a_instr [2];
        logic [15:0] a_pc    [2];
        logic [15:0] a_pc4   [2];
        int          a_cnt   [2];
        a_req[0] = req0;   a_req[1] = req1;
        a_addr[0] = addr0; a_addr[1] = addr1;
        a_valid[0] = valid0; a_valid[1] = valid1;
        a_instr[0] = instr0; a_instr[1] = instr1;
        a_pc[0] = opc0;    a_pc[1] = opc1;
        a_pc4[0] = opc40;  a_pc4[1] = opc41;
        a_cnt[0] = 32'(cnt0); a_cnt[1] = 32'(cnt1);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("imem_req[%0d]", i), 32'(a_req[i]), 32'(exp_req(i)));
            chk($sformatf("imem_addr[%0d]", i), 32'(a_addr[i]), 32'(m_pc[i]));
            chk($sformatf("out_valid[%0d]", i), 32'(a_valid[i]), 32'(m_n[i] != 0));
            chk($sformatf("count[%0d]", i), 32'(a_cnt[i]), 32'(m_n[i]));
            chk($sformatf("no_overflow[%0d]", i), 32'(a_cnt[i] <= depth_of[i]), 32'd1);
            if (m_n[i] != 0) begin
                chk($sformatf("out_pc[%0d]", i), 32'(a_pc[i]), 32'(m_head[i]));
                chk($sformatf("out_pc_plus4[%0d]", i), 32'(a_pc4[i]), 32'(16'(m_head[i] + 16'd4)));
                chk($sformatf("out_instr[%0d]", i), a_instr[i], word(m_head[i]));
            end
            // Three or more cycles clear of any flush, the head is always valid
            if (since_flush >= 3)
                chk($sformatf("throughput[%0d]", i), 32'(a_valid[i]), 32'd1);
        end
    endtask

    task automatic drive(input logic rst, input logic rd, input logic [15:0] rpc, input logic rdy);
        @(negedge clk);
        reset       = rst;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        #1;
        if (rst || rd) since_flush = 0;
        else           since_flush++;
        compare_all();
    endtask

    // Advance the model across one rising edge using the held inputs
    task automatic tick();
        logic r [2];
        logic pop;
        for (int i = 0; i < 2; i++) r[i] = exp_req(i);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_n[i] = 0; m_inf[i] = 1'b0; m_pc[i] = RST_PC;
            end else if (redirect) begin
                m_n[i] = 0; m_inf[i] = 1'b0; m_pc[i] = redirect_pc;
            end else begin
                pop = (m_n[i] != 0) && out_ready;
                if (pop) begin
                    m_head[i] = m_head[i] + 16'd4;
                    m_n[i]--;
                end
                if (m_inf[i]) begin
                    if (m_n[i] == 0) m_head[i] = m_ipc[i];
                    m_n[i]++;
                end
                if (r[i]) begin
                    m_inf[i] = 1'b1;
                    m_ipc[i] = m_pc[i];
                    m_pc[i]  = m_pc[i] + 16'd4;
                end else begin
                    m_inf[i] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        since_flush = 0;
        depth_of[0] = 4;
        depth_of[1] = 2;
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_head[i] = '0; m_pc[i] = RST_PC; m_ipc[i] = '0; m_inf[i] = 1'b0;
        end
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Reset values and sequential streaming
        drive(1'b1, 1'b0, 16'h0, 1'b1);
        chk("rst_req", 32'(req0), 32'd0);
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_count", 32'(cnt0), 32'd0);
        chk("rst_addr", 32'(addr0), 32'h0000);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("first_req", 32'(req0), 32'd1);
        chk("first_addr", 32'(addr0), 32'h0000);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("lat1_valid", 32'(valid0), 32'd0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("lat2_valid", 32'(valid0), 32'd1);
        chk("seq_pc0", 32'(opc0), 32'h0000);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("seq_pc1", 32'(opc0), 32'h0004);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("seq_pc2", 32'(opc0), 32'h0008);
        tick();

        // Back-pressure: fill, hold, then drain in order
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        chk("stall_count", 32'(cnt0), 32'd4);
        chk("stall_req", 32'(req0), 32'd0);
        chk("stall_addr", 32'(addr0), 32'h0010);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b1);
            chk($sformatf("drain_pc%0d", k), 32'(opc0), 32'(4 * k));
            tick();
        end

        // Redirect with three buffered entries and one response in flight
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 16'h0100, 1'b0);
        chk("pre_redir_count", 32'(cnt0), 32'd3);
        chk("redir_req", 32'(req0), 32'd0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("post_redir_count", 32'(cnt0), 32'd0);
        chk("post_redir_valid", 32'(valid0), 32'd0);
        chk("post_redir_addr", 32'(addr0), 32'h0100);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("redir_r2_valid", 32'(valid0), 32'd0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("redir_pc0", 32'(opc0), 32'h0100);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("redir_pc1", 32'(opc0), 32'h0104);
        tick();

        // Reset wins over a simultaneous redirect
        drive(1'b1, 1'b1, 16'h0200, 1'b1);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("rst_over_redir_addr", 32'(addr0), 32'(RST_PC));
        tick();

        // PC wrap at the top of the address space
        drive(1'b0, 1'b1, 16'hFFFC, 1'b1);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("wrap_addr0", 32'(addr0), 32'hFFFC);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("wrap_addr1", 32'(addr0), 32'h0000);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("wrap_pc", 32'(opc0), 32'hFFFC);
        chk("wrap_pc_plus4", 32'(opc40), 32'h0000);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("wrap_next_pc", 32'(opc0), 32'h0000);
        tick();

        // Randomized traffic
        for (int k = 0; k < 1000; k++) begin
            logic rst, rd, rdy;
            logic [15:0] rpc;
            rst = ($urandom_range(0, 199) == 0);
            rd  = !rst && ($urandom_range(0, 29) == 0);
            rpc = 16'($urandom) & 16'hFFFC;
            rdy = 1'($urandom_range(0, 1));
            drive(rst, rd, rpc, rdy);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
